// File: rtl/full_add_sub_unit.sv
// Ripple-carry add/subtract cell: carry_in selects subtract (invert b, inject 1).
// Combinational result/carry_out plus a one-cycle registered copy with overflow.

module fa_stage (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module full_add_sub_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [WIDTH-1:0] result_q,
  output logic             carry_out_q,
  output logic             overflow_q
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
  } res_t;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   c;
  logic             overflow;
  res_t             comb_r, reg_r;

  assign b_eff = b ^ {WIDTH{carry_in}};
  assign c[0]  = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    fa_stage u_fa (
      .a  (a[i]),
      .b  (b_eff[i]),
      .ci (c[i]),
      .s  (result[i]),
      .co (c[i+1])
    );
  end

  assign carry_out = c[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign overflow  = c[WIDTH] ^ c[WIDTH-1];

  assign comb_r = '{result: result, carry: carry_out, ovf: overflow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_r <= '0;
    else        reg_r <= comb_r;
  end

  assign result_q    = reg_r.result;
  assign carry_out_q = reg_r.carry;
  assign overflow_q  = reg_r.ovf;
endmodule

// File: tb/tb_full_add_sub_unit.sv
// Self-checking bench: directed steps plus random/exhaustive checks against an
// integer-arithmetic reference for WIDTH = 1, 4 and 8.

module tb_full_add_sub_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  logic       a1, b1, ci1, r1, co1, rq1, coq1, ovq1;
  logic [3:0] a4, b4, r4, rq4;
  logic       ci4, co4, coq4, ovq4;
  logic [7:0] a8, b8, r8, rq8;
  logic       ci8, co8, coq8, ovq8;

  full_add_sub_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(ci1),
    .result(r1), .carry_out(co1), .result_q(rq1), .carry_out_q(coq1), .overflow_q(ovq1));
  full_add_sub_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .carry_in(ci4),
    .result(r4), .carry_out(co4), .result_q(rq4), .carry_out_q(coq4), .overflow_q(ovq4));
  full_add_sub_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(ci8),
    .result(r8), .carry_out(co8), .result_q(rq8), .carry_out_q(coq8), .overflow_q(ovq8));

  // Reference: returns {overflow, carry_out, result} from plain integer arithmetic.
  function automatic logic [31:0] ref_model(int w, int a, int b, bit sub);
    int m, half, res, sa, sb, sr;
    bit co, ov;
    m    = 1 << w;
    half = m / 2;
    if (sub) begin
      res = (a - b + m) % m;
      co  = (a >= b);
    end else begin
      res = (a + b) % m;
      co  = ((a + b) >= m);
    end
    sa = (a >= half) ? a - m : a;
    sb = (b >= half) ? b - m : b;
    sr = sub ? sa - sb : sa + sb;
    ov = (sr < -half) || (sr >= half);
    return 32'(res) | (32'(co) << w) | (32'(ov) << (w + 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [31:0] e;
    logic [7:0]  ra, rb;
    logic        rc;
    a1 = 0; b1 = 0; ci1 = 0;
    a4 = 0; b4 = 0; ci4 = 0;
    a8 = 0; b8 = 0; ci8 = 0;

    // Reset state
    #2;
    chk("rst_q1", 32'({ovq1, coq1, rq1}), 32'd0);
    chk("rst_q4", 32'({ovq4, coq4, rq4}), 32'd0);
    chk("rst_q8", 32'({ovq8, coq8, rq8}), 32'd0);

    // WIDTH=1 truth table, both modes, combinational only
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 4; i++) begin
        ci1 = m[0]; a1 = i[1]; b1 = i[0];
        #1;
        e = ref_model(1, int'(a1), int'(b1), m[0]);
        chk(m ? "w1_sub" : "w1_add", 32'({co1, r1}), 32'(e[1:0]));
      end
    end
    // Spot-check table values directly
    ci1 = 1; a1 = 1; b1 = 0; #1;
    chk("w1_sub_10", 32'({co1, r1}), 32'd3);
    ci1 = 0; a1 = 1; b1 = 1; #1;
    chk("w1_add_11", 32'({co1, r1}), 32'd2);

    // Registered path, WIDTH=1
    @(negedge clk); rst_n = 1;
    a1 = 1; b1 = 0; ci1 = 1;
    @(posedge clk); #1;
    chk("w1_reg", 32'({ovq1, coq1, rq1}), 32'b011);

    // Asynchronous reset between edges
    #2; rst_n = 0; #1;
    chk("async_rst_q", 32'({ovq1, coq1, rq1}), 32'd0);
    chk("async_rst_comb", 32'({co1, r1}), 32'b11);
    @(negedge clk); rst_n = 1; #1;
    chk("rst_rel_hold", 32'({ovq1, coq1, rq1}), 32'd0);
    @(posedge clk); #1;
    chk("rst_rel_load", 32'({ovq1, coq1, rq1}), 32'b011);

    // WIDTH=4 wrap/borrow/overflow
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; ci4 = 0; #1;
    chk("w4_wrap", 32'({co4, r4}), 32'h10);
    @(posedge clk); #1;
    chk("w4_wrap_ovq", 32'(ovq4), 32'd0);
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h5; ci4 = 1; #1;
    chk("w4_borrow", 32'({co4, r4}), 32'h0E);
    @(negedge clk);
    a4 = 4'h8; b4 = 4'h1; ci4 = 1; #1;
    chk("w4_sub_res", 32'(r4), 32'h7);
    @(posedge clk); #1;
    chk("w4_ovq", 32'(ovq4), 32'd1);

    // WIDTH=4 random registered checks
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
      e = ref_model(4, int'(a4), int'(b4), ci4);
      @(posedge clk); #1;
      chk("w4_rand_q", 32'({ovq4, coq4, rq4}), 32'(e[5:0]));
    end

    // WIDTH=8 random registered checks
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      a8 = ra; b8 = rb; ci8 = rc;
      e = ref_model(8, int'(ra), int'(rb), rc);
      @(posedge clk); #1;
      chk("w8_rand_q", 32'({ovq8, coq8, rq8}), 32'(e[9:0]));
    end

    // WIDTH=8 exhaustive combinational sweep
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 256; x++) begin
        for (int y = 0; y < 256; y++) begin
          a8 = 8'(x); b8 = 8'(y); ci8 = m[0];
          #1;
          e = ref_model(8, x, y, m[0]);
          chk("w8_exh", 32'({co8, r8}), 32'(e[8:0]));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
